// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC op encodings, reset PC and the fetch-state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_B   = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_RA  = 3'b011;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/redirect_target.sv
// Redirect target and taken computation, using the same next-PC rules as the NPC path.
module redirect_target
  import cpu_pkg::*;
#(
  parameter int unsigned NPC_W = 3
) (
  input  logic [NPC_W-1:0] op,
  input  logic [31:0]      pc,
  input  logic [31:0]      offset,
  input  logic [25:0]      j_address,
  input  logic [31:0]      reg_address,
  input  logic             if_branch,
  output logic             taken,
  output logic [31:0]      target
);

  logic [31:0] pc4;

  // Select the target by op; untaken branches and sequential ops do not redirect.
  always_comb begin
    pc4    = pc + 32'd4;
    taken  = 1'b0;
    target = pc4;
    case (op)
      OP_B: begin
        taken  = if_branch;
        target = pc4 + (offset << 2);
      end
      OP_J: begin
        taken  = 1'b1;
        target = {pc4[31:28], j_address, 2'b00};
      end
      OP_RA: begin
        taken  = 1'b1;
        target = reg_address;
      end
      default: begin
        taken  = 1'b0;
        target = pc4;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns the PC, sequences imem req/gnt/rvalid fetches and
// presents instructions to decode with valid/stall. Redirects kill wrong-path fetches.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned  NPC_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             redirect_valid,
  input  logic [NPC_W-1:0] redirect_op,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      offset,
  input  logic [25:0]      j_address,
  input  logic [31:0]      reg_address,
  input  logic             if_branch,
  input  logic             id_stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             misalign_err
);

  fetch_state_e state, state_next;

  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic        kill;

  logic        taken;
  logic [31:0] target;
  logic        redir;
  logic        resp;
  logic        deliver;

  redirect_target #(
    .NPC_W (NPC_W)
  ) u_redirect_target (
    .op          (redirect_op),
    .pc          (redirect_pc),
    .offset      (offset),
    .j_address   (j_address),
    .reg_address (reg_address),
    .if_branch   (if_branch),
    .taken       (taken),
    .target      (target)
  );

  // Qualify redirect and response events used by both the FSM and the datapath.
  always_comb begin
    redir   = redirect_valid && taken;
    resp    = (state == WAIT) && imem_rvalid;
    deliver = resp && !kill && !redir;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_gnt) state_next = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (kill || redir)  state_next = REQ;
          else if (id_stall)  state_next = HOLD;
          else                state_next = REQ;
        end
      end
      HOLD: if (redir || !id_stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs; the address is the PC register, so it is stable until granted.
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  // PC, pending redirect, kill, and IF/ID output registers.
  // A redirect seen in REQ without a grant is parked in pend_pc so imem_addr stays
  // stable; the held fetch completes normally and the next fetch uses the target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      fetch_pc     <= '0;
      pend_pc      <= '0;
      pend_valid   <= 1'b0;
      kill         <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_gnt) begin
            fetch_pc   <= pc;
            pend_valid <= 1'b0;
            kill       <= redir;
            if (redir)           pc <= target;
            else if (pend_valid) pc <= pend_pc;
            else                 pc <= pc + 32'd4;
          end else if (redir) begin
            pend_pc    <= target;
            pend_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (redir) pc <= target;
          if (imem_rvalid) kill <= 1'b0;
          else if (redir)  kill <= 1'b1;
        end
        default: begin
          if (redir) pc <= target;
        end
      endcase

      if (deliver) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= fetch_pc;
      end else if (redir && ((state == HOLD) || resp)) begin
        if_valid <= 1'b0;
      end else if (if_valid && !id_stall) begin
        if_valid <= 1'b0;
      end

      if (redir && (target[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a one-deep instruction memory model.
module tb_fetch_sequencer;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [2:0]  redirect_op;
  logic [31:0] redirect_pc;
  logic [31:0] offset;
  logic [25:0] j_address;
  logic [31:0] reg_address;
  logic        if_branch;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  logic [31:0] last_addr = '0;
  int tests = 0;
  int fails = 0;

  fetch_sequencer #(
    .RESET_PC (32'h0000_3000),
    .NPC_W    (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_op    (redirect_op),
    .redirect_pc    (redirect_pc),
    .offset         (offset),
    .j_address      (j_address),
    .reg_address    (reg_address),
    .if_branch      (if_branch),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Memory model: the response word encodes the granted address.
  always @(posedge clk) if (imem_req && imem_gnt) last_addr <= imem_addr;
  assign imem_rdata = last_addr ^ K;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_op = 3'b000; redirect_pc = '0;
    offset = '0; j_address = '0; reg_address = '0; if_branch = 1'b0; id_stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);

    // 1: free-running fetch
    imem_gnt = 1'b1; imem_rvalid = 1'b1; reset_n = 1'b1;
    tick();  // E1
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h3000);
    tick();  // E2
    check("t1_wait_req", {31'd0, imem_req}, 32'd0);
    tick();  // E3
    check("t1_addr1", imem_addr, 32'h3004);
    check("t1_valid", {31'd0, if_valid}, 32'd1);
    check("t1_ifpc0", if_pc, 32'h3000);
    check("t1_instr0", if_instr, 32'h3000 ^ K);
    tick();  // E4
    check("t1_consumed", {31'd0, if_valid}, 32'd0);
    tick();  // E5
    check("t1_addr2", imem_addr, 32'h3008);
    check("t1_ifpc1", if_pc, 32'h3004);

    // 2: stall for three cycles
    tick();  // E6
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();  // E7..E9
      check("t2_hold_valid", {31'd0, if_valid}, 32'd1);
      check("t2_hold_pc", if_pc, 32'h3008);
      check("t2_hold_instr", if_instr, 32'h3008 ^ K);
      check("t2_hold_req", {31'd0, imem_req}, 32'd0);
    end
    id_stall = 1'b0;
    tick();  // E10
    check("t2_drop", {31'd0, if_valid}, 32'd0);
    check("t2_resume_addr", imem_addr, 32'h300C);
    tick();  // E11
    tick();  // E12
    check("t2_next_pc", if_pc, 32'h300C);
    check("t2_next_addr", imem_addr, 32'h3010);

    // 3: taken branch while waiting for a response
    tick();  // E13
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_op = 3'b001; if_branch = 1'b1;
    redirect_pc = 32'h3010; offset = 32'hFFFF_FFFE;
    tick();  // E14
    check("t3_still_wait", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b0; imem_rvalid = 1'b1;
    tick();  // E15
    check("t3_dropped", {31'd0, if_valid}, 32'd0);
    check("t3_target", imem_addr, 32'h300C);
    tick();  // E16
    tick();  // E17
    check("t3_ifpc", if_pc, 32'h300C);
    check("t3_instr", if_instr, 32'h300C ^ K);
    check("t3_addr", imem_addr, 32'h3010);

    // 4: jump while a request is waiting for grant
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_op = 3'b010; redirect_pc = 32'h3020; j_address = 26'h000_0400;
    tick();  // E18
    check("t4_addr_hold0", imem_addr, 32'h3010);
    check("t4_req", {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b0;
    tick();  // E19
    check("t4_addr_hold1", imem_addr, 32'h3010);
    imem_gnt = 1'b1;
    tick();  // E20
    tick();  // E21
    check("t4_first_valid", {31'd0, if_valid}, 32'd1);
    check("t4_first_pc", if_pc, 32'h3010);
    check("t4_jump_addr", imem_addr, 32'h1000);
    tick();  // E22
    tick();  // E23
    check("t4_target_pc", if_pc, 32'h1000);
    check("t4_seq_addr", imem_addr, 32'h1004);

    // 5: misaligned register redirect in HOLD
    tick();  // E24
    id_stall = 1'b1;
    tick();  // E25
    check("t5_hold_valid", {31'd0, if_valid}, 32'd1);
    check("t5_hold_pc", if_pc, 32'h1004);
    redirect_valid = 1'b1; redirect_op = 3'b011; reg_address = 32'h3002;
    tick();  // E26
    check("t5_flush", {31'd0, if_valid}, 32'd0);
    check("t5_addr", imem_addr, 32'h3002);
    check("t5_mis", {31'd0, misalign_err}, 32'd1);
    redirect_valid = 1'b0; id_stall = 1'b0;
    tick();  // E27
    tick();  // E28
    check("t5_ifpc", if_pc, 32'h3002);
    check("t5_mis_sticky", {31'd0, misalign_err}, 32'd1);
    check("t5_next_addr", imem_addr, 32'h3006);

    // 6: untaken branch then sequential op
    redirect_valid = 1'b1; redirect_op = 3'b001; if_branch = 1'b0;
    redirect_pc = 32'h3000; offset = 32'h10;
    tick();  // E29
    check("t6_wait", {31'd0, imem_req}, 32'd0);
    redirect_op = 3'b000; if_branch = 1'b1;
    tick();  // E30
    redirect_valid = 1'b0;
    check("t6_valid", {31'd0, if_valid}, 32'd1);
    check("t6_ifpc", if_pc, 32'h3006);
    check("t6_addr", imem_addr, 32'h300A);

    // Reset pulse clears sticky error asynchronously
    reset_n = 1'b0;
    #1;
    check("rst2_mis", {31'd0, misalign_err}, 32'd0);
    check("rst2_valid", {31'd0, if_valid}, 32'd0);
    check("rst2_addr", imem_addr, 32'h3000);
    check("rst2_req", {31'd0, imem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
